// File: rtl/alu_sequencer.sv
// Command-level driver for the 4-bit accumulator ALU: runs clear/load/execute/capture
// for one latched two-operand command and presents the 8-bit result with a Done pulse.
module alu_sequencer (
  input  logic       Clock,
  input  logic       Reset_b,
  input  logic       Start,
  input  logic [3:0] Op_a,
  input  logic [3:0] Op_b,
  input  logic [1:0] Op_sel,
  input  logic [7:0] ALUout,
  output logic [3:0] Data,
  output logic [1:0] Function,
  output logic       ALU_reset,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Result
);

  typedef enum logic [2:0] {StIdle, StClr, StLoad, StExec, StCapt} state_e;

  localparam logic [1:0] FnAdd  = 2'b00;
  localparam logic [1:0] FnHold = 2'b11;

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] r_op_a;
  logic [3:0] r_op_b;
  logic [1:0] r_op_sel;
  logic [7:0] r_result;
  logic       r_done;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (Start) w_state_next = StClr;
      StClr:   w_state_next = StLoad;
      StLoad:  w_state_next = StExec;
      StExec:  w_state_next = StCapt;
      StCapt:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Moore outputs toward the ALU
  always_comb begin
    Data      = 4'h0;
    Function  = FnHold;
    ALU_reset = 1'b0;
    Busy      = 1'b1;
    unique case (r_state)
      StIdle: Busy = 1'b0;
      StClr:  ALU_reset = 1'b1;
      StLoad: begin
        Function = FnAdd;
        Data     = r_op_b;
      end
      StExec: begin
        Function = r_op_sel;
        Data     = r_op_a;
      end
      StCapt:  ;
      default: Busy = 1'b0;
    endcase
  end

  // Operand latch, result capture and Done pulse
  always_ff @(posedge Clock) begin
    if (Reset_b) begin
      r_op_a   <= 4'h0;
      r_op_b   <= 4'h0;
      r_op_sel <= 2'b00;
      r_result <= 8'h00;
      r_done   <= 1'b0;
    end else begin
      if (r_state == StIdle && Start) begin
        r_op_a   <= Op_a;
        r_op_b   <= Op_b;
        r_op_sel <= Op_sel;
      end
      if (r_state == StCapt) begin
        r_result <= ALUout;
      end
      r_done <= (r_state == StCapt);
    end
  end

  assign Done   = r_done;
  assign Result = r_result;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural accumulator ALU, directed commands, and a
// result scoreboard popped by an independent Done monitor.
module tb_alu_sequencer;

  logic       Clock = 1'b0;
  logic       Reset_b = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] Op_a = 4'h0;
  logic [3:0] Op_b = 4'h0;
  logic [1:0] Op_sel = 2'b00;
  logic [7:0] ALUout;
  logic [3:0] Data;
  logic [1:0] Function;
  logic       ALU_reset;
  logic       Busy;
  logic       Done;
  logic [7:0] Result;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  alu_sequencer dut (
    .Clock     (Clock),
    .Reset_b   (Reset_b),
    .Start     (Start),
    .Op_a      (Op_a),
    .Op_b      (Op_b),
    .Op_sel    (Op_sel),
    .ALUout    (ALUout),
    .Data      (Data),
    .Function  (Function),
    .ALU_reset (ALU_reset),
    .Busy      (Busy),
    .Done      (Done),
    .Result    (Result)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Accumulator ALU model: registered output, synchronous active-high reset
  logic [7:0] acc;
  always @(posedge Clock) begin
    if (ALU_reset || Reset_b) acc <= 8'h00;
    else begin
      case (Function)
        2'b00: acc <= acc + {4'h0, Data};
        2'b01: acc <= acc * {4'h0, Data};
        2'b10: acc <= acc << Data;
        default: acc <= acc;
      endcase
    end
  end
  assign ALUout = acc;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    if (Done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got Done=1, expected no pending command (cycle %0d)", cyc);
      end else begin
        check("result", Result, exp_q.pop_front());
      end
    end
  end

  // Full command with per-cycle timing checks; inputs scrambled after cycle 0
  task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel,
                         input logic [7:0] exp);
    Op_a = a; Op_b = b; Op_sel = sel; Start = 1'b1;
    exp_q.push_back(exp);
    @(posedge Clock); #1;
    Start = 1'b0; Op_a = ~a; Op_b = ~b; Op_sel = ~sel;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      check("busy_c1_4", {7'd0, Busy}, 8'd1);
      check("no_early_done", {7'd0, Done}, 8'd0);
      if (c == 1) check("alu_reset_clr", {7'd0, ALU_reset}, 8'd1);
      if (c == 2) check("data_load", {4'h0, Data}, {4'h0, b});
      if (c == 3) check("func_exec", {6'd0, Function}, {6'd0, sel});
      @(posedge Clock); #1;
    end
    @(negedge Clock);
    check("done_c5", {7'd0, Done}, 8'd1);
    check("busy_c5", {7'd0, Busy}, 8'd0);
    @(posedge Clock); #1;
  endtask

  initial begin
    int d0;
    int t0;
    int last;
    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    Reset_b = 1'b0;
    @(negedge Clock);
    check("rst_result", Result, 8'h00);
    check("rst_done", {7'd0, Done}, 8'd0);
    check("rst_busy", {7'd0, Busy}, 8'd0);
    check("rst_data", {4'h0, Data}, 8'h00);
    check("rst_function", {6'd0, Function}, 8'd3);
    check("rst_alu_reset", {7'd0, ALU_reset}, 8'd0);
    @(posedge Clock); #1;

    run_cmd(4'd7, 4'd9, 2'b00, 8'h10);
    run_cmd(4'd15, 4'd15, 2'b01, 8'hE1);
    run_cmd(4'd0, 4'd13, 2'b01, 8'h00);
    run_cmd(4'd3, 4'hB, 2'b10, 8'h58);
    run_cmd(4'd7, 4'hF, 2'b10, 8'h80);
    run_cmd(4'd9, 4'hF, 2'b10, 8'h00);
    run_cmd(4'd5, 4'd6, 2'b11, 8'h06);

    // Back-to-back: Start held high, three commands, Done spaced 5 cycles apart
    Op_a = 4'd1; Op_b = 4'd2; Op_sel = 2'b00; Start = 1'b1;
    repeat (3) exp_q.push_back(8'h03);
    last = -1;
    for (int k = 0; k < 3; k++) begin
      t0 = 0;
      do begin
        @(negedge Clock);
        t0++;
      end while (Done !== 1'b1 && t0 < 10);
      if (Done !== 1'b1) check("b2b_done_timeout", {7'd0, Done}, 8'd1);
      if (k == 2) Start = 1'b0;
      if (last >= 0) check("b2b_spacing", 8'(cyc - last), 8'd5);
      last = cyc;
    end
    @(posedge Clock); #1;
    repeat (2) @(posedge Clock);
    #1;

    // Busy rejection: Start with other operands in cycles 1-4 must be ignored
    d0 = n_done;
    Op_a = 4'd4; Op_b = 4'd3; Op_sel = 2'b01; Start = 1'b1;
    exp_q.push_back(8'h0C);
    @(posedge Clock); #1;
    Op_a = 4'd15; Op_b = 4'd15; Op_sel = 2'b00;
    repeat (4) @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (8) @(posedge Clock);
    #1;
    check("busy_reject_one_done", 8'(n_done - d0), 8'd1);

    // Reset mid-command (asserted during cycle 3 of a multiply)
    d0 = n_done;
    Op_a = 4'd3; Op_b = 4'd5; Op_sel = 2'b01; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset_b = 1'b1;
    @(posedge Clock); #1;
    Reset_b = 1'b0;
    @(negedge Clock);
    check("abort_result", Result, 8'h00);
    check("abort_busy", {7'd0, Busy}, 8'd0);
    check("abort_function", {6'd0, Function}, 8'd3);
    check("abort_done", {7'd0, Done}, 8'd0);
    repeat (6) @(posedge Clock);
    #1;
    check("abort_no_done", 8'(n_done - d0), 8'd0);

    run_cmd(4'd2, 4'd3, 2'b00, 8'h05);

    t0 = 0;
    while (exp_q.size() != 0 && t0 < 20) begin
      @(posedge Clock);
      t0++;
    end
    check("pending_results", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
